fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin write-side arbiter that shares one fifo write port between N_REQ requesters.
- Grants one requester at a time and holds that grant for a burst of up to BURST words.
- Registers the selected word onto the fifo write port.
- Throttles all requesters from the fifo almost-full flag, so the shared fifo never overflows.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- WORD_WIDTH, 8, data word width; matches fifo WORD_WIDTH.
- BURST, 4, max words accepted per grant before forced release (≥1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- i_req  input  N_REQ  per-requester valid; word available when high.
- i_data  input  N_REQ*WORD_WIDTH  packed words; requester k occupies bits [k*WORD_WIDTH +: WORD_WIDTH].
- o_ack  output  N_REQ  combinational one-hot accept; requester k's word is consumed on a cycle with o_ack[k]=1.
- o_w_en  output  1  registered fifo write enable.
- o_w_data  output  WORD_WIDTH  registered fifo write data.
- i_afull  input  1  fifo almost-full flag (fifo LEVEL ≥ 1 required).
- o_owner  output  $clog2(N_REQ)  index of the current grant holder; valid while o_busy=1.
- o_busy  output  1  high in GRANT state.

Behaviour:
- Reset, asynchronous assert, any cycle:
  - state=IDLE, rr_ptr=0, count=0, o_owner=0.
  - o_w_en=0, o_w_data=0, o_busy=0, o_ack=0.
  - A registered write in flight is dropped.
- Deassertion: first active edge afterwards behaves as IDLE.
- Two states: IDLE, GRANT.
- IDLE:
  - If any i_req bit is set, owner ← first set index searching rr_ptr, rr_ptr+1, …, wrapping mod N_REQ.
  - count ← 0; go to GRANT.
  - No word is accepted in IDLE (one arbitration cycle per grant). o_ack=0.
- GRANT:
  - Accept condition: i_req[owner] && !i_afull.
  - o_ack[owner] = accept; all other o_ack bits are 0.
  - On accept: next edge o_w_en←1, o_w_data←i_data[owner]. Latency is one cycle from o_ack to o_w_en.
  - Otherwise o_w_en←0 (o_w_data holds).
  - On accept, count increments.
- Release (GRANT→IDLE, rr_ptr ← (owner+1) mod N_REQ) on either:
  - an accept with count==BURST-1, or
  - i_req[owner]==0.
- i_afull high in GRANT:
  - Stall with no accept and no release.
  - count holds; the grant is retained until i_afull drops.
- Requests from non-owners are ignored until release. A requester dropping i_req mid-burst forfeits the rest of its burst.
- count width: $clog2(BURST+1); rr_ptr wrap: N_REQ-1 → 0.
- Fairness: every requester holding i_req high is granted within N_REQ-1 other grants.
- i_data of the owner is sampled only on accept; it may change freely otherwise.
- BURST=1: every accept releases; a single requester gets one word every 2 cycles.
- Max throughput: BURST words per BURST+1 cycles.

Decomposition:
- Package fifo_pkg holds:
  - typedef arb_state_t enum {IDLE, GRANT};
  - function rr_pick(req, ptr), returning the next set index from ptr.
- One sub-module, rr_priority_pick: combinational rotate-and-priority-encode of i_req from rr_ptr. Used by IDLE.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with all i_req=1 -> o_w_en=0, o_ack=0, o_busy=0, o_owner=0 throughout; first grant after release goes to req 0.
- Single requester: i_req=4'b0100, data 0x10..0x17 → o_owner=2. Then 4 words 0x10..0x13 are written on consecutive cycles, 1 IDLE bubble, then 0x14..0x17.
- Round-robin order: i_req=4'b1111 constant, BURST=4 -> bursts of 4 in owner order 0,1,2,3,0; each o_w_en run is exactly 4 long, separated by 1 idle cycle.
- Backpressure: i_afull=1 for 5 cycles mid-burst after 2 accepts -> no o_ack and no o_w_en during the stall, owner unchanged. After i_afull drops, exactly 2 more words complete the burst.
- Early release: owner 1 drops i_req after 1 word while i_req[3]=1 -> release. Next owner is 3 (search starts at 2), and rr_ptr becomes 0 after 3's burst.
- Reset mid-burst: assert reset_n=0 the cycle after an o_ack -> o_w_en=0 immediately (async). That word is not written, and the state is IDLE with rr_ptr=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo write-side arbiter.
package fifo_pkg;

   // Arbiter FSM states: IDLE arbitrates, GRANT streams words from the owner.
   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Widest requester vector the round-robin helper handles.
   localparam int unsigned RR_MAX_REQ = 32'd32;

   // Round-robin pick: first set bit of req searching ptr, ptr+1, ... wrapping
   // modulo n_req. Returns ptr when no bit is set (callers gate with |req).
   function automatic logic [4:0] rr_pick(input logic [31:0] req,
                                          input logic [4:0]  ptr,
                                          input logic [5:0]  n_req);
      logic [4:0] pick;
      logic       found;
      logic [5:0] idx;
      logic [5:0] step;
      pick  = ptr;
      found = 1'b0;
      for (int i = 0; i < 32; i++) begin
         step = 6'(i);
         idx  = {1'b0, ptr} + step;
         if (idx >= n_req) begin
            idx = idx - n_req;
         end else begin
            idx = idx;
         end
         if ((step < n_req) && !found && req[idx[4:0]]) begin
            pick  = idx[4:0];
            found = 1'b1;
         end else begin
            pick  = pick;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotate-and-priority-encode of a request vector from a pointer.
module rr_priority_pick
   import fifo_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
)
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any_req,
   output logic [IDX_W-1:0] pick
);

   // Search starts at ptr so the most recently served requester goes last.
   always_comb begin
      any_req = |req;
      pick    = IDX_W'(rr_pick(32'(req), 5'(ptr), 6'(N_REQ)));
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port between N_REQ requesters.
// A grant is held for up to BURST words; the write port is registered and the
// whole block stalls on the fifo almost-full flag.
module fifo_wr_arbiter
   import fifo_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int WORD_WIDTH = 8,
   parameter int BURST      = 4
)
(
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [N_REQ-1:0]            i_req,
   input  logic [N_REQ*WORD_WIDTH-1:0] i_data,
   output logic [N_REQ-1:0]            o_ack,
   output logic                        o_w_en,
   output logic [WORD_WIDTH-1:0]       o_w_data,
   input  logic                        i_afull,
   output logic [$clog2(N_REQ)-1:0]    o_owner,
   output logic                        o_busy
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(BURST + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

   arb_state_t            state_r;
   arb_state_t            state_nxt_s;
   logic [IDX_W-1:0]      owner_r;
   logic [IDX_W-1:0]      owner_nxt_s;
   logic [IDX_W-1:0]      rr_ptr_r;
   logic [IDX_W-1:0]      rr_ptr_nxt_s;
   logic [CNT_W-1:0]      count_r;
   logic [CNT_W-1:0]      count_nxt_s;
   logic                  w_en_r;
   logic                  w_en_nxt_s;
   logic [WORD_WIDTH-1:0] w_data_r;
   logic [WORD_WIDTH-1:0] w_data_nxt_s;

   logic                  pick_any_s;
   logic [IDX_W-1:0]      pick_idx_s;
   logic [N_REQ-1:0]      owner_onehot_s;
   logic                  owner_req_s;
   logic [WORD_WIDTH-1:0] owner_word_s;
   logic                  accept_s;
   logic [N_REQ-1:0]      ack_s;
   logic [IDX_W-1:0]      release_ptr_s;

   rr_priority_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_pick (
      .req     (i_req),
      .ptr     (rr_ptr_r),
      .any_req (pick_any_s),
      .pick    (pick_idx_s)
   );

   // Select the owner's request bit and data word through a one-hot decode.
   always_comb begin
      owner_onehot_s = {N_REQ{1'b0}};
      owner_req_s    = 1'b0;
      owner_word_s   = {WORD_WIDTH{1'b0}};
      for (int k = 0; k < N_REQ; k++) begin
         if (owner_r == IDX_W'(k)) begin
            owner_onehot_s[k] = 1'b1;
            owner_req_s       = i_req[k];
            owner_word_s      = i_data[k*WORD_WIDTH +: WORD_WIDTH];
         end else begin
            owner_onehot_s[k] = 1'b0;
         end
      end
   end

   // Next-state, counters, write-port next values and the combinational ack.
   always_comb begin
      state_nxt_s   = state_r;
      owner_nxt_s   = owner_r;
      rr_ptr_nxt_s  = rr_ptr_r;
      count_nxt_s   = count_r;
      w_en_nxt_s    = 1'b0;
      w_data_nxt_s  = w_data_r;
      accept_s      = 1'b0;
      ack_s         = {N_REQ{1'b0}};
      if (owner_r == LAST_IDX) begin
         release_ptr_s = {IDX_W{1'b0}};
      end else begin
         release_ptr_s = owner_r + IDX_W'(1);
      end
      case (state_r)
         IDLE: begin
            // One arbitration cycle per grant; nothing is accepted here.
            if (pick_any_s) begin
               owner_nxt_s = pick_idx_s;
               count_nxt_s = {CNT_W{1'b0}};
               state_nxt_s = GRANT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         GRANT: begin
            if (i_afull) begin
               // Stall: grant and burst count are frozen until space returns.
               state_nxt_s = GRANT;
            end else if (!owner_req_s) begin
               // Owner went quiet: it forfeits the rest of its burst.
               state_nxt_s  = IDLE;
               rr_ptr_nxt_s = release_ptr_s;
            end else begin
               accept_s     = 1'b1;
               ack_s        = owner_onehot_s;
               w_en_nxt_s   = 1'b1;
               w_data_nxt_s = owner_word_s;
               count_nxt_s  = count_r + CNT_W'(1);
               if (count_r == LAST_CNT) begin
                  state_nxt_s  = IDLE;
                  rr_ptr_nxt_s = release_ptr_s;
               end else begin
                  state_nxt_s  = GRANT;
               end
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State and write-port registers; reset also drops a write in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r  <= IDLE;
         owner_r  <= {IDX_W{1'b0}};
         rr_ptr_r <= {IDX_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         w_en_r   <= 1'b0;
         w_data_r <= {WORD_WIDTH{1'b0}};
      end else begin
         state_r  <= state_nxt_s;
         owner_r  <= owner_nxt_s;
         rr_ptr_r <= rr_ptr_nxt_s;
         count_r  <= count_nxt_s;
         w_en_r   <= w_en_nxt_s;
         w_data_r <= w_data_nxt_s;
      end
   end

   assign o_ack    = ack_s;
   assign o_w_en   = w_en_r;
   assign o_w_data = w_data_r;
   assign o_owner  = owner_r;
   assign o_busy   = (state_r == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed phases push expected writes,
// a monitor pops and compares them whenever o_w_en is seen.
module tb_fifo_wr_arbiter;

   logic        clk;
   logic        reset_n;
   logic [3:0]  i_req;
   logic [31:0] i_data;
   logic [3:0]  o_ack;
   logic        o_w_en;
   logic [7:0]  o_w_data;
   logic        i_afull;
   logic [1:0]  o_owner;
   logic        o_busy;

   typedef struct {
      logic [7:0] data;
      int         gap;   // idle cycles since previous write, -1 = don't care
   } exp_t;

   exp_t       exp_q[$];
   int         errors;
   int         checks;
   logic [7:0] base [4];
   logic [7:0] cnt  [4];
   logic [3:0] ack_seen;

   fifo_wr_arbiter #(
      .N_REQ      (4),
      .WORD_WIDTH (8),
      .BURST      (4)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_req    (i_req),
      .i_data   (i_data),
      .o_ack    (o_ack),
      .o_w_en   (o_w_en),
      .o_w_data (o_w_data),
      .i_afull  (i_afull),
      .o_owner  (o_owner),
      .o_busy   (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic push(input logic [7:0] d, input int g);
      exp_t e;
      e.data = d;
      e.gap  = g;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      #1;
      chk(name, 32'(exp_q.size()), 32'd0);
   endtask

   // Producer: each requester advances its word after every acknowledged edge.
   initial begin
      ack_seen = 4'h0;
      forever begin
         @(negedge clk);
         ack_seen = o_ack;
         @(posedge clk);
         #2;
         for (int k = 0; k < 4; k++) begin
            if (ack_seen[k]) cnt[k] = cnt[k] + 8'd1;
            i_data[k*8 +: 8] = base[k] + cnt[k];
         end
      end
   end

   // Monitor: every write must match the head of the scoreboard queue.
   initial begin
      exp_t e;
      int   idle_cnt;
      idle_cnt = 0;
      forever begin
         @(negedge clk);
         if (o_w_en) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got data %0h, required no write", o_w_data);
            end else begin
               e = exp_q.pop_front();
               chk("write_data", 32'(o_w_data), 32'(e.data));
               if (e.gap >= 0) chk("write_gap", 32'(idle_cnt), 32'(e.gap));
            end
            idle_cnt = 0;
         end else begin
            idle_cnt++;
         end
      end
   end

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required end of stimulus");
      $fatal(1, "watchdog expired");
   end

   // Directed stimulus phases.
   initial begin
      errors  = 0;
      checks  = 0;
      i_req   = 4'hF;
      i_afull = 1'b0;
      i_data  = 32'h0;
      for (int k = 0; k < 4; k++) begin
         base[k] = 8'(k * 16);
         cnt[k]  = 8'h00;
      end
      reset_n = 1'b1;
      #1 reset_n = 1'b0;

      // Reset held with every requester asking.
      repeat (3) begin
         @(negedge clk);
         chk("rst_w_en",  32'(o_w_en),  32'd0);
         chk("rst_ack",   32'(o_ack),   32'd0);
         chk("rst_busy",  32'(o_busy),  32'd0);
         chk("rst_owner", 32'(o_owner), 32'd0);
      end

      // Round robin: owners 0,1,2,3,0, bursts of 4 with one idle between.
      for (int b = 0; b < 5; b++) begin
         for (int w = 0; w < 4; w++) begin
            push(8'(((b % 4) * 16) + ((b / 4) * 4) + w),
                 (b == 0 && w == 0) ? -1 : ((w == 0) ? 1 : 0));
         end
      end
      @(posedge clk);
      #1 reset_n = 1'b1;
      tick();
      @(negedge clk);
      chk("rr_first_owner", 32'(o_owner), 32'd0);
      chk("rr_first_busy",  32'(o_busy),  32'd1);
      chk("rr_first_ack",   32'(o_ack),   32'h1);
      repeat (24) tick();
      i_req = 4'h0;
      drain("rr_drain");

      // Single requester 2: two bursts with one arbitration bubble.
      tick();
      base[2] = 8'h10;
      cnt[2]  = 8'h00;
      i_req   = 4'b0100;
      for (int w = 0; w < 8; w++) begin
         push(8'(8'h10 + w), (w == 0) ? -1 : ((w == 4) ? 1 : 0));
      end
      tick();
      @(negedge clk);
      chk("single_owner", 32'(o_owner), 32'd2);
      chk("single_busy",  32'(o_busy),  32'd1);
      repeat (9) tick();
      i_req = 4'h0;
      drain("single_drain");

      // Backpressure: requester 3 stalls for 5 cycles after two accepts.
      tick();
      base[3] = 8'h40;
      cnt[3]  = 8'h00;
      i_req   = 4'b1000;
      push(8'h40, -1);
      push(8'h41, 0);
      push(8'h42, 5);
      push(8'h43, 0);
      repeat (3) tick();
      i_afull = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_ack",   32'(o_ack),   32'd0);
         chk("stall_owner", 32'(o_owner), 32'd3);
         if (i > 0) chk("stall_w_en", 32'(o_w_en), 32'd0);
      end
      tick();
      i_afull = 1'b0;
      @(negedge clk);
      chk("unstall_owner", 32'(o_owner), 32'd3);
      chk("unstall_ack",   32'(o_ack),   32'h8);
      repeat (2) tick();
      i_req = 4'h0;
      drain("stall_drain");

      // Early release: owner 1 quits after one word, search resumes at 2.
      tick();
      base[1] = 8'h50;
      cnt[1]  = 8'h00;
      base[3] = 8'h60;
      cnt[3]  = 8'h00;
      i_req   = 4'b1010;
      push(8'h50, -1);
      push(8'h60, 2);
      push(8'h61, 0);
      push(8'h62, 0);
      push(8'h63, 0);
      tick();
      @(negedge clk);
      chk("early_owner1", 32'(o_owner), 32'd1);
      tick();
      i_req = 4'b1000;
      repeat (2) tick();
      @(negedge clk);
      chk("early_owner3", 32'(o_owner), 32'd3);
      repeat (4) tick();

      // rr_ptr back to 0: full request set goes to 0, then reset mid-burst of 1.
      base[0] = 8'h70;
      cnt[0]  = 8'h00;
      base[1] = 8'h80;
      cnt[1]  = 8'h00;
      i_req   = 4'b1111;
      push(8'h70, 1);
      push(8'h71, 0);
      push(8'h72, 0);
      push(8'h73, 0);
      tick();
      @(negedge clk);
      chk("wrap_owner0", 32'(o_owner), 32'd0);
      repeat (6) tick();
      chk("inflight_w_en", 32'(o_w_en), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("midrst_w_en",  32'(o_w_en),  32'd0);
      chk("midrst_busy",  32'(o_busy),  32'd0);
      chk("midrst_owner", 32'(o_owner), 32'd0);
      chk("midrst_ack",   32'(o_ack),   32'd0);
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;
      tick();
      @(negedge clk);
      chk("postrst_owner", 32'(o_owner), 32'd0);
      chk("postrst_busy",  32'(o_busy),  32'd1);
      i_req = 4'h0;
      drain("final_drain");
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
